// File: rtl/ram_stream_reader.sv
// ram_stream_reader: read-side sequencer for simple_ram.
// On a start pulse it walks a wrap-around address window of the RAM read
// port and streams each word out over valid/ready, flagging the final beat.
// A 4-entry buffer absorbs the RAM's one-cycle read latency and any
// downstream backpressure.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle transfer request (ignored while busy)
//   base_addr, length transfer window, sampled with start (length 0..D)
//   rdaddress         registered read address to the RAM
//   q                 RAM read data for the address presented one edge earlier
//   out_data/out_last stream payload, valid while out_valid is high
//   out_valid         buffer head holds a beat
//   out_ready         consumer accepts the head beat
//   busy              transfer in progress
//   done              one-cycle pulse at transfer completion
module ram_stream_reader #(
  parameter int unsigned width   = 8,
  parameter int unsigned widthad = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [widthad-1:0] base_addr,
  input  logic [widthad:0]   length,
  output logic [widthad-1:0] rdaddress,
  input  logic [width-1:0]   q,
  output logic [width-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam int unsigned LEN_W     = widthad + 1;
  localparam int unsigned BUF_DEPTH = 4;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [widthad-1:0]                rdaddr_d;
  logic [widthad-1:0]                nxt_addr_q, nxt_addr_d;
  logic [LEN_W-1:0]                  remain_q, remain_d;
  logic                              s1_vld_q, s1_vld_d;
  logic                              s1_last_q, s1_last_d;
  logic                              s2_vld_q, s2_last_q;
  logic [BUF_DEPTH-1:0][width-1:0]   data_q, data_d;
  logic [BUF_DEPTH-1:0]              last_q, last_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d, cnt_pop, credit_used;
  logic                              pop, push, issue;
  logic                              busy_d, done_d;

  // Head of the shift-register buffer is the stream output.
  assign out_data = data_q[0];
  assign out_last = last_q[0];

  assign pop  = out_valid && out_ready;
  assign push = s2_vld_q;

  // Buffered beats plus reads still in the RAM pipeline may never exceed the
  // buffer depth, so a push always finds a free slot.
  assign credit_used = cnt_q + CNT_W'(s1_vld_q) + CNT_W'(s2_vld_q);
  assign issue       = (state_q == RUN) && (remain_q != '0) &&
                       (credit_used < CNT_W'(BUF_DEPTH));

  // Next-state, read issue and buffer update.
  always_comb begin
    state_d    = state_q;
    rdaddr_d   = rdaddress;
    nxt_addr_d = nxt_addr_q;
    remain_d   = remain_q;
    s1_vld_d   = 1'b0;
    s1_last_d  = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;
    data_d     = data_q;
    last_d     = last_q;
    cnt_pop    = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            // First read goes out on the same edge that samples start.
            state_d    = RUN;
            busy_d     = 1'b1;
            rdaddr_d   = base_addr;
            nxt_addr_d = base_addr + widthad'(1);
            remain_d   = length - LEN_W'(1);
            s1_vld_d   = 1'b1;
            s1_last_d  = (length == LEN_W'(1));
          end
        end
      end
      RUN: begin
        if (issue) begin
          rdaddr_d   = nxt_addr_q;
          nxt_addr_d = nxt_addr_q + widthad'(1);
          remain_d   = remain_q - LEN_W'(1);
          s1_vld_d   = 1'b1;
          s1_last_d  = (remain_q == LEN_W'(1));
        end
        if (pop && out_last) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pop shifts every entry one slot toward the head.
    if (pop) begin
      data_d  = data_q >> width;
      last_d  = last_q >> 1;
      cnt_pop = cnt_q - CNT_W'(1);
    end
    // Push lands just behind the last occupied slot after any pop.
    if (push) begin
      data_d[cnt_pop[IDX_W-1:0]] = q;
      last_d[cnt_pop[IDX_W-1:0]] = s2_last_q;
    end
    cnt_d = cnt_pop + CNT_W'(push);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rdaddress  <= '0;
      nxt_addr_q <= '0;
      remain_q   <= '0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      data_q     <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdaddress  <= rdaddr_d;
      nxt_addr_q <= nxt_addr_d;
      remain_q   <= remain_d;
      s1_vld_q   <= s1_vld_d;
      s1_last_q  <= s1_last_d;
      s2_vld_q   <= s1_vld_q;
      s2_last_q  <= s1_last_q;
      data_q     <= data_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      out_valid  <= (cnt_d != '0);
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural registered-read RAM
// whose contents are mem[k] = k + 16.
module tb_ram_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] length;
  logic [3:0] rdaddress;
  logic [7:0] q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  ram_stream_reader #(.width(8), .widthad(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .rdaddress (rdaddress),
    .q         (q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM read port: one-cycle registered read, mem[k] = k + 16.
  always @(posedge clk) q <= {4'h0, rdaddress} + 8'd16;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer from a sample point with the FSM idle. rpat gives
  // out_ready per cycle; inject_at >= 0 pulses a stray start mid-transfer.
  task automatic run_xfer(input logic [3:0] b, input int n, input logic [15:0] rpat,
                          input int inject_at);
    int         acc;
    int         iss;
    int         cyc;
    logic       stalled;
    logic [7:0] held;
    logic [3:0] ea;
    start     = 1'b1;
    base_addr = b;
    length    = 5'(n);
    out_ready = rpat[0];
    step();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("rdaddr_first", {28'd0, rdaddress}, {28'd0, b});
    iss = 1; acc = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (acc < n && cyc < 300) begin
      if (stalled) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hold", {24'd0, out_data}, {24'd0, held});
      end
      ea = b + 4'(iss);
      if (iss < n && rdaddress == ea) iss++;
      chk("issue_ahead", {31'd0, ((iss - acc) <= 4)}, 32'd1);
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("no_early_done", {31'd0, done}, 32'd0);
      out_ready = rpat[cyc % 16];
      if (cyc == inject_at) begin
        start     = 1'b1;
        base_addr = 4'd9;
        length    = 5'd3;
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          ea = b + 4'(acc);
          chk("beat_data", {24'd0, out_data}, {28'd0, ea} + 32'd16);
          chk("beat_last", {31'd0, out_last}, {31'd0, (acc == n - 1)});
          acc++;
        end else begin
          stalled = 1'b1;
          held    = out_data;
        end
      end
      step();
      start = 1'b0;
      cyc++;
    end
    chk("all_beats", acc, n);
    chk("issued_all", iss, n);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_in_finish", {31'd0, busy}, 32'd1);
    chk("empty_in_finish", {31'd0, out_valid}, 32'd0);
    step();
    chk("done_cleared", {31'd0, done}, 32'd0);
    chk("busy_cleared", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_rdaddress", {28'd0, rdaddress}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    #20;
    step();
    rst_n = 1'b1;
    step();

    // Basic: base 2, length 4, consumer always ready.
    start = 1'b1; base_addr = 4'd2; length = 5'd4; out_ready = 1'b1;
    step();                                   // E0
    start = 1'b0;
    chk("basic_busy", {31'd0, busy}, 32'd1);
    chk("basic_addr0", {28'd0, rdaddress}, 32'd2);
    chk("basic_novalid_e0", {31'd0, out_valid}, 32'd0);
    step();                                   // E1
    chk("basic_addr1", {28'd0, rdaddress}, 32'd3);
    chk("basic_novalid_e1", {31'd0, out_valid}, 32'd0);
    step();                                   // E2
    chk("basic_valid_e2", {31'd0, out_valid}, 32'd1);
    chk("basic_d0", {24'd0, out_data}, 32'd18);
    chk("basic_l0", {31'd0, out_last}, 32'd0);
    step();
    chk("basic_d1", {24'd0, out_data}, 32'd19);
    chk("basic_l1", {31'd0, out_last}, 32'd0);
    step();
    chk("basic_d2", {24'd0, out_data}, 32'd20);
    chk("basic_l2", {31'd0, out_last}, 32'd0);
    step();
    chk("basic_d3", {24'd0, out_data}, 32'd21);
    chk("basic_l3", {31'd0, out_last}, 32'd1);
    chk("basic_v3", {31'd0, out_valid}, 32'd1);
    step();                                   // last beat accepted
    chk("basic_done", {31'd0, done}, 32'd1);
    chk("basic_busy_fin", {31'd0, busy}, 32'd1);
    chk("basic_empty", {31'd0, out_valid}, 32'd0);
    chk("basic_addr_hold", {28'd0, rdaddress}, 32'd5);
    step();
    chk("basic_done_off", {31'd0, done}, 32'd0);
    chk("basic_busy_off", {31'd0, busy}, 32'd0);

    // Zero length: done only, no busy, no beats, address untouched.
    start = 1'b1; base_addr = 4'd7; length = 5'd0;
    step();
    start = 1'b0;
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_valid", {31'd0, out_valid}, 32'd0);
    chk("zero_addr_hold", {28'd0, rdaddress}, 32'd5);
    step();
    chk("zero_done_off", {31'd0, done}, 32'd0);
    chk("zero_busy_off", {31'd0, busy}, 32'd0);
    chk("zero_valid_off", {31'd0, out_valid}, 32'd0);

    // Wrap-around window 14,15,0,1.
    run_xfer(4'd14, 4, 16'hFFFF, -1);
    // Backpressure over a full 16-word window.
    run_xfer(4'd0, 16, 16'h9669, -1);
    // Full length from base 5, ending at mem[4].
    run_xfer(4'd5, 16, 16'hFFFF, -1);
    // Stray start mid-transfer must be ignored.
    run_xfer(4'd3, 6, 16'hFFFF, 2);

    // Reset after 2 of 8 beats.
    start = 1'b1; base_addr = 4'd0; length = 5'd8; out_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();           // beats accepted at E3, E4
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdaddress", {28'd0, rdaddress}, 32'd0);
    chk("mid_rst_out_data", {24'd0, out_data}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_last", {31'd0, out_last}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_done", {31'd0, done}, 32'd0);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("post_rst_done2", {31'd0, done}, 32'd0);
    run_xfer(4'd10, 5, 16'hFFFF, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
